// File: rtl/rr_bank_arbiter_if.sv
// Consumer request/response and PLM bank port bundle for rr_bank_arbiter.
// master = consumer/PLM side, slave = arbiter side.
interface rr_bank_arbiter_if #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned VALUE_WIDTH = 8,
   parameter int unsigned NCONSUMERS  = 4,
   parameter int unsigned NBANKS      = 2
);
   localparam int unsigned OFFSET_WIDTH = ADDR_WIDTH - $clog2(NBANKS);

   logic [NCONSUMERS-1:0]                  req_valid;
   logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]  req_addr;
   logic [NCONSUMERS-1:0]                  req_wr;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] req_wdata;
   logic [NCONSUMERS-1:0]                  req_ready;

   logic [NBANKS-1:0]                      plm_en;
   logic [NBANKS-1:0]                      plm_we;
   logic [NBANKS-1:0][OFFSET_WIDTH-1:0]    plm_addr;
   logic [NBANKS-1:0][VALUE_WIDTH-1:0]     plm_wdata;
   logic [NBANKS-1:0][VALUE_WIDTH-1:0]     plm_rdata;

   logic [NCONSUMERS-1:0]                  resp_valid;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_rdata;

   modport master (
      output req_valid, req_addr, req_wr, req_wdata, plm_rdata,
      input  req_ready, plm_en, plm_we, plm_addr, plm_wdata, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_wr, req_wdata, plm_rdata,
      output req_ready, plm_en, plm_we, plm_addr, plm_wdata, resp_valid, resp_rdata
   );
endinterface

// File: rtl/rr_bank_arbiter.sv
// Per-bank round-robin arbitration of consumer requests onto single-port PLM banks,
// with a fixed-latency tag pipeline routing read data back to the requester.
module rr_bank_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned VALUE_WIDTH  = 8,
   parameter int unsigned NCONSUMERS   = 4,
   parameter int unsigned NBANKS       = 2,
   parameter int unsigned READ_LATENCY = 1
) (
   input logic              clk,
   input logic              reset_n,
   rr_bank_arbiter_if.slave bus
);
   localparam int unsigned NUM_BANK_BITS = $clog2(NBANKS);
   localparam int unsigned OFFSET_WIDTH  = ADDR_WIDTH - NUM_BANK_BITS;
   localparam int unsigned CID_WIDTH     = $clog2(NCONSUMERS);

   typedef logic [CID_WIDTH-1:0]     cid_t;
   typedef logic [NUM_BANK_BITS-1:0] bank_t;

   cid_t              ptr     [NBANKS];
   logic [NBANKS-1:0] gnt_vld;
   cid_t              gnt_id  [NBANKS];
   logic [NBANKS-1:0] rd_issue;

   logic [NBANKS-1:0][READ_LATENCY-1:0] tag_vld;
   cid_t                                tag_cid [NBANKS][READ_LATENCY];

   // Explicit wrap so non-power-of-2 consumer counts cycle correctly.
   function automatic cid_t cid_inc(input cid_t c);
      if (32'(c) == NCONSUMERS - 1) return '0;
      return c + cid_t'(1);
   endfunction

   function automatic bank_t bank_of(input logic [ADDR_WIDTH-1:0] a);
      return a[ADDR_WIDTH-1 -: NUM_BANK_BITS];
   endfunction

   // Cyclic scan from each bank's pivot; grants are held off while in reset.
   always_comb begin
      cid_t cand;
      logic found;
      cand  = '0;
      found = 1'b0;
      for (int unsigned b = 0; b < NBANKS; b++) begin
         gnt_vld[b] = 1'b0;
         gnt_id[b]  = '0;
         found      = 1'b0;
         cand       = ptr[b];
         for (int unsigned i = 0; i < NCONSUMERS; i++) begin
            if (!found && reset_n && bus.req_valid[cand] &&
                bank_of(bus.req_addr[cand]) == bank_t'(b)) begin
               found      = 1'b1;
               gnt_vld[b] = 1'b1;
               gnt_id[b]  = cand;
            end
            cand = cid_inc(cand);
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      bus.plm_en    = '0;
      bus.plm_we    = '0;
      bus.plm_addr  = '0;
      bus.plm_wdata = '0;
      rd_issue      = '0;
      for (int unsigned b = 0; b < NBANKS; b++) begin
         if (gnt_vld[b]) begin
            bus.req_ready[gnt_id[b]] = 1'b1;
            bus.plm_en[b]            = 1'b1;
            bus.plm_we[b]            = bus.req_wr[gnt_id[b]];
            bus.plm_addr[b]          = bus.req_addr[gnt_id[b]][OFFSET_WIDTH-1:0];
            bus.plm_wdata[b]         = bus.req_wdata[gnt_id[b]];
            rd_issue[b]              = ~bus.req_wr[gnt_id[b]];
         end
      end
   end

   // Pivots start staggered per bank so banks do not favour the same consumer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned b = 0; b < NBANKS; b++) begin
            ptr[b] <= cid_t'(b % NCONSUMERS);
         end
      end else begin
         for (int unsigned b = 0; b < NBANKS; b++) begin
            if (gnt_vld[b]) begin
               ptr[b] <= cid_inc(gnt_id[b]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld <= '0;
         for (int unsigned b = 0; b < NBANKS; b++) begin
            for (int unsigned s = 0; s < READ_LATENCY; s++) begin
               tag_cid[b][s] <= '0;
            end
         end
      end else begin
         for (int unsigned b = 0; b < NBANKS; b++) begin
            tag_vld[b][0] <= rd_issue[b];
            tag_cid[b][0] <= gnt_id[b];
            for (int unsigned s = 1; s < READ_LATENCY; s++) begin
               tag_vld[b][s] <= tag_vld[b][s-1];
               tag_cid[b][s] <= tag_cid[b][s-1];
            end
         end
      end
   end

   // Equal latency on every bank and one grant per consumer means no two
   // banks can target the same consumer in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.resp_valid <= '0;
         bus.resp_rdata <= '0;
      end else begin
         bus.resp_valid <= '0;
         for (int unsigned b = 0; b < NBANKS; b++) begin
            if (tag_vld[b][READ_LATENCY-1]) begin
               bus.resp_valid[tag_cid[b][READ_LATENCY-1]] <= 1'b1;
               bus.resp_rdata[tag_cid[b][READ_LATENCY-1]] <= bus.plm_rdata[b];
            end
         end
      end
   end
endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Directed bench for rr_bank_arbiter: a cycle model of the arbitration rules plus
// a small PLM memory, with literal expectations at the key points.
module tb_rr_bank_arbiter;
   localparam int unsigned AW = 4;
   localparam int unsigned VW = 8;
   localparam int unsigned NC = 4;
   localparam int unsigned NB = 2;
   localparam int unsigned RL = 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rr_bank_arbiter_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB)) bus ();

   rr_bank_arbiter #(
      .ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC), .NBANKS(NB), .READ_LATENCY(RL)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bench-side PLM: one-cycle registered read, write at the edge.
   logic [7:0] pmem [NB][8];
   bit plm_init = 1'b0;
   always @(posedge clk) begin
      if (!plm_init) begin
         for (int b = 0; b < NB; b++)
            for (int o = 0; o < 8; o++) pmem[b][o] <= 8'(8'h20 * (b + 1) + o * 3 + 1);
         pmem[1][2] <= 8'h5C;
         bus.plm_rdata <= '0;
         plm_init <= 1'b1;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (bus.plm_en[b]) begin
               if (bus.plm_we[b]) pmem[b][bus.plm_addr[b]] <= bus.plm_wdata[b];
               else bus.plm_rdata[b] <= pmem[b][bus.plm_addr[b]];
            end
         end
      end
   end

   // Model: pivots, expected reads due at grant cycle + RL + 1, last delivered data.
   typedef struct { int due; int cid; logic [7:0] data; } pend_t;
   pend_t q[$];
   int mptr[NB];
   logic [7:0] mlast[NC];
   int cyc = 0;

   always @(negedge clk) begin
      logic [NC-1:0] e_ready, e_rv;
      logic [NB-1:0] e_en, e_we;
      logic [NB-1:0][2:0] e_addr;
      logic [NB-1:0][7:0] e_wd;
      logic [NC-1:0][7:0] e_rd;
      int c;
      bit found;
      cyc++;
      e_ready = '0; e_rv = '0; e_en = '0; e_we = '0; e_addr = '0; e_wd = '0;
      if (!reset_n) begin
         for (int b = 0; b < NB; b++) mptr[b] = b % NC;
         q.delete();
         for (int k = 0; k < NC; k++) mlast[k] = '0;
      end else begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
               e_rv[q[i].cid] = 1'b1;
               mlast[q[i].cid] = q[i].data;
               q.delete(i);
            end
         end
         for (int b = 0; b < NB; b++) begin
            found = 1'b0;
            for (int k = 0; k < NC; k++) begin
               c = (mptr[b] + k) % NC;
               if (!found && bus.req_valid[c] && int'(bus.req_addr[c][3]) == b) begin
                  found = 1'b1;
                  e_ready[c] = 1'b1;
                  e_en[b] = 1'b1;
                  e_we[b] = bus.req_wr[c];
                  e_addr[b] = bus.req_addr[c][2:0];
                  e_wd[b] = bus.req_wdata[c];
                  if (!bus.req_wr[c]) q.push_back('{cyc + RL + 1, c, pmem[b][bus.req_addr[c][2:0]]});
                  mptr[b] = (c + 1) % NC;
               end
            end
         end
      end
      for (int k = 0; k < NC; k++) e_rd[k] = mlast[k];
      chk("model_req_ready", 64'(bus.req_ready), 64'(e_ready));
      chk("model_plm_en", 64'(bus.plm_en), 64'(e_en));
      chk("model_plm_we", 64'(bus.plm_we), 64'(e_we));
      chk("model_plm_addr", 64'(bus.plm_addr), 64'(e_addr));
      chk("model_plm_wdata", 64'(bus.plm_wdata), 64'(e_wd));
      chk("model_resp_valid", 64'(bus.resp_valid), 64'(e_rv));
      chk("model_resp_rdata", 64'(bus.resp_rdata), 64'(e_rd));
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int c, input logic [3:0] a, input logic wr, input logic [7:0] wd);
      bus.req_valid[c] = 1'b1;
      bus.req_addr[c]  = a;
      bus.req_wr[c]    = wr;
      bus.req_wdata[c] = wd;
   endtask

   task automatic idle();
      bus.req_valid = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_wr    = '0;
      bus.req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset pivots: ptr1=1, so a lone c0 on bank1 still wins; then all four -> c1.
      set_req(0, 4'h8, 1'b0, 8'h00);
      @(negedge clk); chk("rst_lone_c0_bank1", 64'(bus.req_ready), 64'b0001);
      next_cyc(); idle();
      repeat (3) next_cyc();
      for (int c = 0; c < NC; c++) set_req(c, 4'(8 + c), 1'b0, 8'h00);
      @(negedge clk); chk("rst_all_bank1_first", 64'(bus.req_ready), 64'b0010);
      next_cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_ready", 64'(bus.req_ready), 64'h0);
      chk("async_rst_plm_en", 64'(bus.plm_en), 64'h0);
      chk("async_rst_rdata", 64'(bus.resp_rdata), 64'h0);
      idle();
      repeat (2) next_cyc();
      reset_n = 1'b1;

      // Single read c2 @0xA.
      set_req(2, 4'hA, 1'b0, 8'h00);
      @(negedge clk);
      chk("single_ready", 64'(bus.req_ready), 64'b0100);
      chk("single_plm_en", 64'(bus.plm_en), 64'b10);
      chk("single_plm_addr1", 64'(bus.plm_addr[1]), 64'h2);
      chk("single_plm_we", 64'(bus.plm_we), 64'h0);
      next_cyc(); idle();
      @(negedge clk); chk("single_no_early_resp", 64'(bus.resp_valid), 64'h0);
      next_cyc();
      @(negedge clk);
      chk("single_resp_valid", 64'(bus.resp_valid), 64'b0100);
      chk("single_resp_rdata2", 64'(bus.resp_rdata[2]), 64'h5C);
      next_cyc();
      @(negedge clk); chk("single_resp_one_cycle", 64'(bus.resp_valid), 64'h0);
      next_cyc();

      // Contention on bank0 straight out of reset.
      reset_n = 1'b0;
      next_cyc();
      reset_n = 1'b1;
      for (int c = 0; c < NC; c++) set_req(c, 4'(c), 1'b0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("rr_grant%0d", k), 64'(bus.req_ready), 64'(1 << (k % 4)));
         next_cyc();
      end
      idle();
      repeat (3) next_cyc();

      // Parallel banks.
      set_req(0, 4'h1, 1'b0, 8'h00);
      set_req(1, 4'h9, 1'b0, 8'h00);
      @(negedge clk);
      chk("par_ready", 64'(bus.req_ready), 64'b0011);
      chk("par_plm_en", 64'(bus.plm_en), 64'b11);
      next_cyc(); idle();
      next_cyc();
      @(negedge clk); chk("par_resp_valid", 64'(bus.resp_valid), 64'b0011);
      next_cyc();

      // Write, no response, then read it back.
      set_req(3, 4'h3, 1'b1, 8'h7F);
      @(negedge clk);
      chk("wr_plm_en", 64'(bus.plm_en), 64'b01);
      chk("wr_plm_we", 64'(bus.plm_we), 64'b01);
      chk("wr_plm_addr0", 64'(bus.plm_addr[0]), 64'h3);
      chk("wr_plm_wdata0", 64'(bus.plm_wdata[0]), 64'h7F);
      next_cyc(); idle();
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.resp_valid != '0) seen++;
         next_cyc();
      end
      chk("wr_no_resp", 64'(seen), 64'h0);
      set_req(0, 4'h3, 1'b0, 8'h00);
      next_cyc(); idle();
      next_cyc();
      @(negedge clk); chk("wr_readback", 64'(bus.resp_rdata[0]), 64'h7F);
      next_cyc();

      // Reset while a read is in flight.
      set_req(1, 4'h5, 1'b0, 8'h00);
      @(negedge clk); chk("inflight_accept", 64'(bus.req_ready), 64'b0010);
      next_cyc(); idle();
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.resp_valid[1]) seen++;
         next_cyc();
      end
      chk("inflight_discarded", 64'(seen), 64'h0);

      repeat (2) next_cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
